// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared definitions for the DSP MAC sequencer: FSM states, token field layout
// and the legal pipeline-depth range.
package dsp_mac_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int TOK_V     = 0;
  localparam int TOK_FIRST = 1;
  localparam int TOK_LAST  = 2;
  localparam int TOK_W     = 3;

  localparam int PIPE_DEPTH_MIN = 2;
  localparam int PIPE_DEPTH_MAX = 8;

  function automatic bit pipe_depth_ok(input int depth);
    return (depth >= PIPE_DEPTH_MIN) && (depth <= PIPE_DEPTH_MAX);
  endfunction

endpackage

// File: rtl/dsp_tok_pipe.sv
// Non-stalling shift register of {last, first, v} tokens that shadows the
// datapath stages; every stage is exposed so the controller can derive enables.
module dsp_tok_pipe
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TOK_W-1:0]             tok_in,
  output logic [DEPTH-1:0][TOK_W-1:0]  tok
);

  logic [DEPTH-1:0][TOK_W-1:0] tok_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) tok_reg[gi] <= '0;
          else     tok_reg[gi] <= tok_in;
        end
      end else begin : g_body
        always_ff @(posedge clk) begin
          if (rst) tok_reg[gi] <= '0;
          else     tok_reg[gi] <= tok_reg[gi-1];
        end
      end
    end
  endgenerate

  assign tok = tok_reg;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Control FSM for a pipelined DSP multiply-accumulate slice: counts operand
// accepts for a run and drives per-stage enables, clear and load/accumulate.
module dsp_mac_sequencer
  import dsp_mac_sequencer_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [PIPE_DEPTH-1:0] ce_stage,
  output logic                  acc_load,
  output logic                  dsp_rst,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  busy
);

  generate
    if (!pipe_depth_ok(PIPE_DEPTH)) begin : g_bad_depth
      $error("dsp_mac_sequencer: PIPE_DEPTH out of range 2..8");
    end
  endgenerate

  state_t                            state_reg;
  state_t                            state_next;
  logic   [LEN_W-1:0]                remaining_reg;
  logic                              first_pending_reg;
  logic                              accept;
  logic                              last_accept;
  logic                              last_at_p;
  logic   [TOK_W-1:0]                tok_in;
  logic   [PIPE_DEPTH-1:0][TOK_W-1:0] tok;

  assign accept      = in_ready & in_valid;
  assign last_accept = accept && (remaining_reg == LEN_W'(1));
  // Token at stage PIPE_DEPTH-2 drives the P-register update this cycle.
  assign last_at_p   = tok[PIPE_DEPTH-2][TOK_V] & tok[PIPE_DEPTH-2][TOK_LAST];

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = (len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:   if (last_accept) state_next = ST_DRAIN;
      ST_DRAIN: if (last_at_p) state_next = ST_DONE;
      ST_DONE:  if (res_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_reg == ST_RUN);
    res_valid = (state_reg == ST_DONE);
    busy      = (state_reg != ST_IDLE);
    dsp_rst   = (state_reg == ST_IDLE) && start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_reg     <= '0;
      first_pending_reg <= 1'b0;
    end else if ((state_reg == ST_IDLE) && start) begin
      remaining_reg     <= len;
      first_pending_reg <= 1'b1;
    end else if (accept) begin
      remaining_reg     <= remaining_reg - 1'b1;
      first_pending_reg <= 1'b0;
    end
  end

  always_comb begin
    tok_in            = '0;
    tok_in[TOK_V]     = accept;
    tok_in[TOK_FIRST] = accept & first_pending_reg;
    tok_in[TOK_LAST]  = last_accept;
  end

  dsp_tok_pipe #(
    .DEPTH (PIPE_DEPTH)
  ) u_tok_pipe (
    .clk    (clk),
    .rst    (rst),
    .tok_in (tok_in),
    .tok    (tok)
  );

  assign ce_stage[0] = accept;
  generate
    for (genvar gi = 1; gi < PIPE_DEPTH; gi++) begin : g_ce
      assign ce_stage[gi] = tok[gi-1][TOK_V];
    end
  endgenerate

  assign acc_load = tok[PIPE_DEPTH-2][TOK_FIRST] & tok[PIPE_DEPTH-2][TOK_V];

  // The final stage and unused flag bits exist for observability only.
  logic unused_tok;
  assign unused_tok = ^tok;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed plus randomized bench for dsp_mac_sequencer against a time-based
// model that predicts each output from the history of accepts in the run.
module tb_dsp_mac_sequencer;

  localparam int D  = 3;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [D-1:0]  ce_stage;
  logic          acc_load;
  logic          dsp_rst;
  logic          res_valid;
  logic          res_ready;
  logic          busy;

  always #5 clk = ~clk;

  dsp_mac_sequencer #(
    .PIPE_DEPTH (D),
    .LEN_W      (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ce_stage  (ce_stage),
    .acc_load  (acc_load),
    .dsp_rst   (dsp_rst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: a run is active from start until the result is taken.
  int now        = 0;
  bit active     = 0;
  int run_len    = 0;
  int n_acc      = 0;
  int first_acc  = -1;
  int done_at    = -1;
  int valid_from = 0;
  bit hist [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, now, obs, exp);
    end
  endtask

  task automatic model_reset();
    active     = 0;
    run_len    = 0;
    n_acc      = 0;
    first_acc  = -1;
    done_at    = -1;
    valid_from = now + 1;
  endtask

  task automatic step(input bit s, input int l, input bit iv, input bit rr, input bit r);
    logic [D-1:0] ce_e;
    bit ir_e, acc_e, rv_e, ld_e;
    @(negedge clk);
    rst = r; start = s; len = l[LW-1:0]; in_valid = iv; res_ready = rr;
    #1;
    ir_e  = active && (n_acc < run_len);
    acc_e = ir_e && iv;
    rv_e  = active && (done_at >= 0) && (now >= done_at);
    ld_e  = (first_acc >= 0) && (now - first_acc == D - 1);
    ce_e[0] = acc_e;
    for (int i = 1; i < D; i++)
      ce_e[i] = (now - i >= valid_from) && (now - i >= 0) && hist[now - i];
    chk("in_ready",  32'(in_ready),  32'(ir_e));
    chk("ce_stage",  32'(ce_stage),  32'(ce_e));
    chk("acc_load",  32'(acc_load),  32'(ld_e));
    chk("dsp_rst",   32'(dsp_rst),   32'(!active && s));
    chk("res_valid", 32'(res_valid), 32'(rv_e));
    chk("busy",      32'(busy),      32'(active));
    $display("cyc %0d rst=%0b start=%0b len=%0d iv=%0b rr=%0b | rdy=%0b ce=%b ld=%0b drst=%0b rv=%0b busy=%0b",
             now, r, s, l, iv, rr, in_ready, ce_stage, acc_load, dsp_rst, res_valid, busy);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (!active) begin
      if (s) begin
        active    = 1;
        run_len   = l;
        n_acc     = 0;
        first_acc = -1;
        done_at   = (l == 0) ? now + 1 : -1;
      end
    end else begin
      if (acc_e) begin
        hist[now] = 1;
        if (n_acc == 0) first_acc = now;
        n_acc++;
        if (n_acc == run_len) done_at = now + D;
      end
      if (rv_e && rr) active = 0;
    end
    now++;
  endtask

  initial begin
    rst = 1; start = 0; len = '0; in_valid = 0; res_ready = 0;
    repeat (2) @(posedge clk);
    valid_from = 0;
    step(0, 0, 0, 0, 0);

    // len=1, in_valid held high, result taken a couple of cycles late
    step(1, 1, 1, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // len=4 back-to-back
    step(1, 4, 0, 0, 0);
    repeat (8) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    // len=3 with bubbles
    step(1, 3, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, (i % 2) == 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    // len=0
    step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // reset mid-run after 2 of 5 accepts, then a fresh len=2 run
    step(1, 5, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    repeat (6) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    // start during DRAIN/DONE ignored, result held without res_ready
    step(1, 2, 0, 0, 0);
    repeat (2) step(0, 0, 1, 0, 0);
    step(1, 6, 1, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    repeat (10) step((now % 2) == 0, 3, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 6)),
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3,
           $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Control block for a DSP multiply-accumulate slice built from parameterised register/bypass stages: input regs, M reg, P (accumulator) reg.
- Accepts a run length, then streams operand handshakes, and drives the slice's per-stage clock-enables, reset and accumulate/load select.
- Signals result-valid when the last term has landed in P, and holds it until the consumer acknowledges.
- Sits between the operand source / result consumer and the DSP datapath; carries no data itself.

Parameters:
- PIPE_DEPTH, 3, number of registered stages from operand capture to P update (stage 0 = input regs, stage PIPE_DEPTH-1 = P reg); legal range 2..8.
- LEN_W, 8, width of run-length field; max terms = 2^LEN_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- len  in  LEN_W  number of terms; sampled with start.
- in_valid  in  1  operand pair present on datapath inputs.
- in_ready  out  1  controller accepts operand this cycle.
- ce_stage  out  PIPE_DEPTH  per-stage clock-enable to datapath registers.
- acc_load  out  1  when 1 with ce_stage[PIPE_DEPTH-1], P <= M (load); when 0, P <= P+M.
- dsp_rst  out  1  one-cycle synchronous clear of all datapath registers.
- res_valid  out  1  P holds the completed sum.
- res_ready  in  1  consumer takes the result.
- busy  out  1  state != IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high, ports named clk and rst.
- States:
  - IDLE: start=1 latches len into remaining counter and pulses dsp_rst this same cycle. If len=0 go to DONE, else go to RUN.
  - RUN: in_ready=1. An accept (in_valid&in_ready) decrements remaining; the accept that makes remaining 0 goes to DRAIN.
  - DRAIN: in_ready=0; wait until the token carrying last exits the P stage, then go to DONE.
  - DONE: res_valid=1. When res_ready=1, go to IDLE.
- Token pipe:
  - tok[0..PIPE_DEPTH-1], each {v, first, last}. tok[0] loads on accept; tok[i] <= tok[i-1] every cycle.
  - Pipe never stalls; the consumer back-pressures only in DONE, after the pipe is empty.
  - first = first accept of the run; last = accept that makes remaining 0.
- Enables:
  - ce_stage[0] = accept (combinational).
  - ce_stage[i] = tok[i-1].v for i >= 1.
  - acc_load = tok[PIPE_DEPTH-2].first & tok[PIPE_DEPTH-2].v.
- Latency: accept in cycle c ⇒ P loaded at end of c+PIPE_DEPTH-1 ⇒ res_valid high from cycle c+PIPE_DEPTH when that token is last. Back-to-back accepts give one term per cycle.
- len=0: dsp_rst clears P; res_valid is asserted the cycle after start; the result is 0.
- start outside IDLE is ignored. in_valid outside RUN is ignored, with no accept.
- Reset (including mid-run): state=IDLE, remaining=0, all tok.v=0. Outputs in_ready=0, ce_stage=0, acc_load=0, dsp_rst=0, res_valid=0, busy=0. Reset does not itself drive dsp_rst; the datapath has its own rst.
- res_ready while res_valid=0 has no effect. res_valid never drops without res_ready.

Decomposition:
- Shared include/package: state encodings (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3), token field offsets, and the PIPE_DEPTH legal-range check.
- One sub-module: dsp_tok_pipe, the PIPE_DEPTH-deep {v, first, last} shift register with rst clear, exposing all stages.
- The FSM and length counter stay in the top.

Test Plan:
- PIPE_DEPTH=3, start with len=1, in_valid held high -> accept in cycle 1; ce_stage = 001, 010, 100 in cycles 1-3; acc_load=1 in cycle 3; res_valid from cycle 4; res_ready in cycle 6 -> IDLE in cycle 7.
- len=4, in_valid continuous -> 4 consecutive accepts; acc_load=1 only for the first P update; res_valid 3 cycles after the 4th accept; in_ready=0 after the 4th accept.
- len=3, in_valid toggling 1,0,1,0,1 -> exactly 3 accepts; ce_stage bits show gaps matching the bubbles; res_valid PIPE_DEPTH cycles after the final accept.
- len=0 -> dsp_rst pulse in the start cycle; res_valid the next cycle; no ce_stage activity.
- rst asserted in RUN after 2 of 5 accepts -> next cycle all outputs 0 and state IDLE; a new start with len=2 completes normally with acc_load on its first term.
- start pulsed during DRAIN/DONE and res_ready held low 10 cycles in DONE -> start ignored; res_valid stays high until res_ready.
